input_debouncer: RTL and testbench



---
 rtl/io_pkg.sv | 21 ++
 rtl/debounce_bit.sv | 67 ++++++
 rtl/input_debouncer.sv | 93 +++++++++
 tb/tb_input_debouncer.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_pkg.sv
// Shared I/O definitions for the switch/button conditioning path.
// Holds the board input width, default debounce timing and a width helper.
package io_pkg;

    localparam int unsigned IO_SW_WIDTH        = 19;
    localparam int unsigned DEF_SAMPLE_DIV     = 100000;
    localparam int unsigned DEF_STABLE_SAMPLES = 10;

    // Bits needed to hold values 0..v-1, never less than 1
    function automatic int unsigned clog2_min1(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << r) < 64'(v)) begin
                r = r + 1;
            end
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/debounce_bit.sv
// One conditioned input: 2-FF synchronizer, stability counter advanced on
// the shared sample tick, clean level and registered edge pulses.
module debounce_bit
    import io_pkg::*;
#(
    parameter int unsigned STABLE_SAMPLES = DEF_STABLE_SAMPLES,
    parameter int unsigned CNT_W          = clog2_min1(STABLE_SAMPLES + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic raw,
    output logic clean,
    output logic rise,
    output logic fall
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_SAMPLES - 1);

    logic             s1;
    logic             s2;
    logic [CNT_W-1:0] cnt;
    logic             accept;

    // A new level is taken on the tick that completes the run of differing samples
    assign accept = tick && (s2 != clean) && (cnt == CNT_LAST);

    // Two-stage synchronizer for the asynchronous pad input
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= raw;
            s2 <= s1;
        end
    end

    // Stability counter and clean level, both frozen between ticks
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            clean <= 1'b0;
        end else if (tick) begin
            if (s2 == clean) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                clean <= s2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Edge pulses register alongside clean so they mark its first new cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            rise <= accept & s2;
            fall <= accept & ~s2;
        end
    end

endmodule

// File: rtl/input_debouncer.sv
// Switch/button debouncer feeding the memory-mapped I/O block.
// Shared sample-tick prescaler, WIDTH debounce_bit instances and, when
// DEBOUNCE_EVENT_LATCH_EN is defined, sticky press flags with an irq line.
module input_debouncer
    import io_pkg::*;
#(
    parameter int unsigned WIDTH          = IO_SW_WIDTH,
    parameter int unsigned SAMPLE_DIV     = DEF_SAMPLE_DIV,
    parameter int unsigned STABLE_SAMPLES = DEF_STABLE_SAMPLES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] raw_in,
    output logic [WIDTH-1:0] clean_out,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse,
    input  logic             clr_en,
    input  logic [WIDTH-1:0] clr_mask,
    output logic [WIDTH-1:0] event_pending,
    output logic             irq
);

    localparam int unsigned DIV_W = clog2_min1(SAMPLE_DIV);
    localparam int unsigned CNT_W = clog2_min1(STABLE_SAMPLES + 1);

    logic tick;

    generate
        if (SAMPLE_DIV == 1) begin : g_tick_always
            assign tick = 1'b1;
        end else begin : g_prescaler
            localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
            logic [DIV_W-1:0] div_cnt;

            // Free-running prescaler wrapping at SAMPLE_DIV-1
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    div_cnt <= '0;
                end else if (div_cnt == DIV_LAST) begin
                    div_cnt <= '0;
                end else begin
                    div_cnt <= div_cnt + 1'b1;
                end
            end

            assign tick = (div_cnt == DIV_LAST);
        end
    endgenerate

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            debounce_bit #(
                .STABLE_SAMPLES (STABLE_SAMPLES),
                .CNT_W          (CNT_W)
            ) u_bit (
                .clk   (clk),
                .rst_n (rst_n),
                .tick  (tick),
                .raw   (raw_in[i]),
                .clean (clean_out[i]),
                .rise  (rise_pulse[i]),
                .fall  (fall_pulse[i])
            );
        end
    endgenerate

`ifdef DEBOUNCE_EVENT_LATCH_EN
    // Sticky press flags: a new rise overrides a clear in the same cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            event_pending <= '0;
        end else begin
            event_pending <= (event_pending & ~(clr_en ? clr_mask : '0)) | rise_pulse;
        end
    end

    // Interrupt follows the flags one cycle later
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq <= 1'b0;
        end else begin
            irq <= |event_pending;
        end
    end
`else
    logic unused_clr;

    assign unused_clr    = &{1'b0, clr_en, clr_mask};
    assign event_pending = '0;
    assign irq           = 1'b0;
`endif

endmodule

// File: tb/tb_input_debouncer.sv
// Directed self-checking bench for input_debouncer with SAMPLE_DIV=4,
// STABLE_SAMPLES=3, WIDTH=19. Event-latch checks follow DEBOUNCE_EVENT_LATCH_EN.
module tb_input_debouncer;

    localparam int W = 19;
    localparam logic [W-1:0] ALL1 = 19'h7FFFF;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] raw_in = '0;
    logic [W-1:0] clean_out;
    logic [W-1:0] rise_pulse;
    logic [W-1:0] fall_pulse;
    logic         clr_en = 1'b0;
    logic [W-1:0] clr_mask = '0;
    logic [W-1:0] event_pending;
    logic         irq;

    int checks = 0;
    int failures = 0;

    input_debouncer #(
        .WIDTH          (W),
        .SAMPLE_DIV     (4),
        .STABLE_SAMPLES (3)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .raw_in        (raw_in),
        .clean_out     (clean_out),
        .rise_pulse    (rise_pulse),
        .fall_pulse    (fall_pulse),
        .clr_en        (clr_en),
        .clr_mask      (clr_mask),
        .event_pending (event_pending),
        .irq           (irq)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [W-1:0] raw_val);
        rst_n    = 1'b0;
        raw_in   = raw_val;
        clr_en   = 1'b0;
        clr_mask = '0;
        repeat (3) step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        int first;
        int nrise;
        int rise_at;
        int early;
        logic [W-1:0] rise_val;
        rst_n  = 1'b0;
        raw_in = ALL1;
        repeat (3) step();
        checks++;
        if (clean_out !== '0) begin
            failures++;
            $display("FAIL reset_clean: got %h want 00000", clean_out);
        end
        checks++;
        if (rise_pulse !== '0 || fall_pulse !== '0) begin
            failures++;
            $display("FAIL reset_pulses: got rise=%h fall=%h want 0", rise_pulse, fall_pulse);
        end
        checks++;
        if (event_pending !== '0 || irq !== 1'b0) begin
            failures++;
            $display("FAIL reset_events: got pend=%h irq=%b want 0", event_pending, irq);
        end
        rst_n = 1'b1;
        first = 0; nrise = 0; rise_at = 0; early = 0; rise_val = '0;
        for (int c = 1; c <= 20; c++) begin
            step();
            if (first == 0 && clean_out === ALL1) first = c;
            if (first == 0 && clean_out !== '0) early++;
            if (rise_pulse !== '0) begin
                nrise++;
                rise_at  = c;
                rise_val = rise_pulse;
            end
        end
        checks++;
        if (first < 11 || first > 14) begin
            failures++;
            $display("FAIL reset_latency: got %0d cycles want 11..14", first);
        end
        checks++;
        if (early != 0) begin
            failures++;
            $display("FAIL reset_early_clean: got %0d nonzero cycles want 0", early);
        end
        checks++;
        if (nrise != 1 || rise_at != first || rise_val !== ALL1) begin
            failures++;
            $display("FAIL reset_rise: got n=%0d at=%0d val=%h want n=1 at=%0d val=7ffff",
                     nrise, rise_at, rise_val, first);
        end
    endtask

    task automatic test_glitch();
        int bad_clean;
        int bad_pulse;
        do_reset('0);
        raw_in[0] = 1'b1;
        bad_clean = 0; bad_pulse = 0;
        for (int c = 1; c <= 35; c++) begin
            step();
            if (c == 5) raw_in[0] = 1'b0;
            if (clean_out[0] !== 1'b0) bad_clean++;
            if (rise_pulse !== '0 || fall_pulse !== '0) bad_pulse++;
        end
        checks++;
        if (bad_clean != 0) begin
            failures++;
            $display("FAIL glitch_clean: got %0d cycles with clean[0]=1 want 0", bad_clean);
        end
        checks++;
        if (bad_pulse != 0) begin
            failures++;
            $display("FAIL glitch_pulse: got %0d pulse cycles want 0", bad_pulse);
        end
    endtask

    task automatic test_bounce();
        int early_rise;
        int nfall;
        int nrise;
        int rise_at;
        early_rise = 0; nfall = 0; nrise = 0; rise_at = 0;
        for (int c = 0; c < 30; c++) begin
            raw_in[4] = (((c / 3) % 2) == 0);
            step();
            if (rise_pulse[4] === 1'b1) early_rise++;
            if (fall_pulse[4] === 1'b1) nfall++;
        end
        raw_in[4] = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            step();
            if (rise_pulse[4] === 1'b1) begin
                nrise++;
                rise_at = c;
            end
            if (fall_pulse[4] === 1'b1) nfall++;
        end
        checks++;
        if (early_rise != 0 || nrise != 1) begin
            failures++;
            $display("FAIL bounce_rise_count: got during=%0d after=%0d want 0 and 1", early_rise, nrise);
        end
        checks++;
        if (rise_at < 1 || rise_at > 14) begin
            failures++;
            $display("FAIL bounce_rise_time: got %0d want 1..14", rise_at);
        end
        checks++;
        if (nfall != 0 || clean_out[4] !== 1'b1) begin
            failures++;
            $display("FAIL bounce_final: got falls=%0d clean4=%b want 0 and 1", nfall, clean_out[4]);
        end
    endtask

    task automatic test_release();
        bit seen;
        int nfall;
        int nrise;
        int low_at;
        raw_in[2] = 1'b1;
        seen = 0;
        for (int c = 1; c <= 20 && !seen; c++) begin
            step();
            if (clean_out[2] === 1'b1) seen = 1;
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL release_setup: got clean2=%b want 1 within 20 cycles", clean_out[2]);
        end
        raw_in[2] = 1'b0;
        nfall = 0; nrise = 0; low_at = 0;
        for (int c = 1; c <= 20; c++) begin
            step();
            if (low_at == 0 && clean_out[2] === 1'b0) low_at = c;
            if (fall_pulse[2] === 1'b1) nfall++;
            if (rise_pulse[2] === 1'b1) nrise++;
        end
        checks++;
        if (nfall != 1 || nrise != 0) begin
            failures++;
            $display("FAIL release_pulses: got fall=%0d rise=%0d want 1 and 0", nfall, nrise);
        end
        checks++;
        if (low_at < 11 || low_at > 14) begin
            failures++;
            $display("FAIL release_latency: got %0d want 11..14", low_at);
        end
    endtask

    task automatic test_midcount_reset();
        int first;
        int stray;
        raw_in = 19'h00200;
        repeat (6) step();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (clean_out !== '0 || rise_pulse !== '0 || fall_pulse !== '0) begin
            failures++;
            $display("FAIL async_reset: got clean=%h rise=%h fall=%h want 0", clean_out, rise_pulse, fall_pulse);
        end
        checks++;
        if (event_pending !== '0 || irq !== 1'b0) begin
            failures++;
            $display("FAIL async_reset_events: got pend=%h irq=%b want 0", event_pending, irq);
        end
        repeat (2) step();
        rst_n = 1'b1;
        first = 0; stray = 0;
        for (int c = 1; c <= 20; c++) begin
            step();
            if (first == 0 && clean_out[9] === 1'b1) first = c;
            if ((clean_out & ~19'h00200) !== '0) stray++;
        end
        checks++;
        if (first != 12) begin
            failures++;
            $display("FAIL restart_latency: got %0d want 12", first);
        end
        checks++;
        if (stray != 0 || clean_out !== 19'h00200) begin
            failures++;
            $display("FAIL restart_clean: got %h stray=%0d want 00200", clean_out, stray);
        end
    endtask

`ifdef DEBOUNCE_EVENT_LATCH_EN
    task automatic test_event_latch();
        bit seen;
        do_reset('0);
        raw_in[7] = 1'b1;
        seen = 0;
        for (int c = 1; c <= 20 && !seen; c++) begin
            step();
            if (rise_pulse[7] === 1'b1) seen = 1;
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL event_first_rise: got no rise_pulse[7] want one within 20 cycles");
        end
        step();
        checks++;
        if (event_pending !== 19'h00080) begin
            failures++;
            $display("FAIL event_set: got %h want 00080", event_pending);
        end
        step();
        checks++;
        if (irq !== 1'b1) begin
            failures++;
            $display("FAIL event_irq: got %b want 1", irq);
        end
        raw_in[7] = 1'b0;
        seen = 0;
        for (int c = 1; c <= 20 && !seen; c++) begin
            step();
            if (clean_out[7] === 1'b0) seen = 1;
        end
        raw_in[7] = 1'b1;
        seen = 0;
        for (int c = 1; c <= 20 && !seen; c++) begin
            step();
            if (rise_pulse[7] === 1'b1) seen = 1;
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL event_second_rise: got no rise_pulse[7] want one within 20 cycles");
        end
        clr_en   = 1'b1;
        clr_mask = 19'h00080;
        step();
        clr_en = 1'b0;
        checks++;
        if (event_pending !== 19'h00080) begin
            failures++;
            $display("FAIL event_set_wins: got %h want 00080", event_pending);
        end
        repeat (2) step();
        clr_en = 1'b1;
        step();
        clr_en = 1'b0;
        checks++;
        if (event_pending !== '0) begin
            failures++;
            $display("FAIL event_clear: got %h want 00000", event_pending);
        end
        step();
        checks++;
        if (irq !== 1'b0) begin
            failures++;
            $display("FAIL event_irq_clear: got %b want 0", irq);
        end
    endtask
`else
    task automatic test_event_latch();
        int bad;
        do_reset('0);
        raw_in[7] = 1'b1;
        clr_en    = 1'b1;
        clr_mask  = ALL1;
        bad = 0;
        for (int c = 1; c <= 20; c++) begin
            step();
            if (event_pending !== '0 || irq !== 1'b0) bad++;
        end
        clr_en = 1'b0;
        checks++;
        if (clean_out[7] !== 1'b1) begin
            failures++;
            $display("FAIL event_tied_press: got clean7=%b want 1", clean_out[7]);
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL event_tied: got %0d cycles with pend/irq set want 0", bad);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_glitch();
        test_bounce();
        test_release();
        test_midcount_reset();
        test_event_latch();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
